// File: rtl/op_counter_pkg.sv
// Shared state encoding for the operation cycle counter and the multdiv control.
package op_counter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } op_state_e;

endpackage

// File: rtl/op_cycle_counter_regn.sv
// Generic WIDTH-bit register with synchronous reset to RST_VAL and load enable.
module regn #(
    parameter int               WIDTH   = 6,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Storage: reset wins, otherwise load when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end else begin
            o_q <= o_q;
        end
    end

endmodule

// File: rtl/op_cycle_counter.sv
// Counts max(terminal,1) cycles after an accepted start and flags completion
// with a pulse (or a held ready when STICKY=1); optional periodic reload.
module op_cycle_counter
    import op_counter_pkg::*;
#(
    parameter int WIDTH  = 6,
    parameter int STICKY = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] terminal,
    input  logic             auto_reload,
    input  logic             abort,
    input  logic             ack,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] count,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_bits_d;
    op_state_e          w_state;
    op_state_e          w_state_d;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_d;
    logic [WIDTH-1:0]   r_term;
    logic [WIDTH-1:0]   w_term_d;
    logic               r_reload;
    logic               r_overrun;
    logic               w_accept;
    logic               w_over_set;
    logic               w_term_hit;

    assign w_state        = op_state_e'(r_state);
    assign w_state_bits_d = w_state_d;
    assign w_term_d       = (terminal == {WIDTH{1'b0}}) ? ONE : terminal;
    assign w_term_hit     = (w_state == ST_RUN) && (r_count == r_term);

    regn #(.WIDTH(STATE_W), .RST_VAL(2'd0)) u_state_reg (
        .i_clk(clk), .i_rst(reset), .i_en(1'b1), .i_d(w_state_bits_d), .o_q(r_state)
    );

    regn #(.WIDTH(WIDTH), .RST_VAL({WIDTH{1'b0}})) u_count_reg (
        .i_clk(clk), .i_rst(reset), .i_en(1'b1), .i_d(w_count_d), .o_q(r_count)
    );

    regn #(.WIDTH(WIDTH), .RST_VAL(ONE)) u_term_reg (
        .i_clk(clk), .i_rst(reset), .i_en(w_accept), .i_d(w_term_d), .o_q(r_term)
    );

    // Next-state and next-count; abort outranks every other request.
    always_comb begin
        w_state_d  = w_state;
        w_count_d  = r_count;
        w_accept   = 1'b0;
        w_over_set = 1'b0;
        if (abort) begin
            w_state_d = ST_IDLE;
            w_count_d = {WIDTH{1'b0}};
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (start) begin
                        w_accept  = 1'b1;
                        w_state_d = ST_RUN;
                        w_count_d = ONE;
                    end else begin
                        w_count_d = {WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    if (w_term_hit) begin
                        if (r_reload) begin
                            w_count_d = ONE;
                        end else if (start) begin
                            // Back-to-back: restart straight from the terminal cycle.
                            w_accept  = 1'b1;
                            w_count_d = ONE;
                        end else if ((STICKY == 0) || ack) begin
                            w_state_d = ST_IDLE;
                            w_count_d = {WIDTH{1'b0}};
                        end else begin
                            w_state_d = ST_DONE;
                        end
                    end else begin
                        w_count_d  = r_count + ONE;
                        w_over_set = start;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        w_accept  = 1'b1;
                        w_state_d = ST_RUN;
                        w_count_d = ONE;
                    end else if (ack) begin
                        w_state_d = ST_IDLE;
                        w_count_d = {WIDTH{1'b0}};
                    end else begin
                        w_count_d = r_term;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_count_d = {WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Reload mode latch and the reset-only overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reload  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_reload  <= w_accept ? auto_reload : r_reload;
            r_overrun <= r_overrun | w_over_set;
        end
    end

    assign busy    = (w_state == ST_RUN);
    assign ready   = !abort && (w_term_hit || (w_state == ST_DONE));
    assign count   = r_count;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_op_cycle_counter.sv
// Bench for op_cycle_counter: a pulse-mode and a sticky-mode instance share stimulus.
module tb_op_cycle_counter;

    logic       clk = 1'b0;
    logic       reset, start, auto_reload, abort, ack;
    logic [5:0] terminal;
    logic [1:0] o_busy, o_ready, o_ovr;
    logic [1:0][5:0] o_count;

    int n_err = 0;
    int n_chk = 0;

    // Reference model state, index 0 = pulse instance, 1 = sticky instance.
    bit m_run [2];
    bit m_done[2];
    bit m_per [2];
    bit m_ovr [2];
    int m_n   [2];
    int m_T   [2];

    always #5 clk = ~clk;

    op_cycle_counter #(.WIDTH(6), .STICKY(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .terminal(terminal),
        .auto_reload(auto_reload), .abort(abort), .ack(ack),
        .busy(o_busy[0]), .ready(o_ready[0]), .count(o_count[0]), .overrun(o_ovr[0])
    );

    op_cycle_counter #(.WIDTH(6), .STICKY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .terminal(terminal),
        .auto_reload(auto_reload), .abort(abort), .ack(ack),
        .busy(o_busy[1]), .ready(o_ready[1]), .count(o_count[1]), .overrun(o_ovr[1])
    );

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
        auto_reload = 1'b0; terminal = 6'd0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int s = 0; s < 2; s++) begin
            n_chk++;
            if (o_busy[s] !== 1'b0 || o_ready[s] !== 1'b0 || o_count[s] !== 6'd0 || o_ovr[s] !== 1'b0) begin
                n_err++;
                $display("FAIL reset inst%0d: busy=%b ready=%b count=%0d ovr=%b, want 0 0 0 0",
                         s, o_busy[s], o_ready[s], o_count[s], o_ovr[s]);
            end
        end
    endtask

    task automatic test_one_shot();
        do_reset();
        terminal = 6'd32; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            #1;
            n_chk++;
            if (o_ready[0] !== (k == 32) || o_busy[0] !== (k <= 32) ||
                o_count[0] !== ((k <= 32) ? 6'(k) : 6'd0)) begin
                n_err++;
                $display("FAIL one_shot cycle %0d: ready=%b busy=%b count=%0d, want %b %b %0d",
                         k, o_ready[0], o_busy[0], o_count[0], (k == 32), (k <= 32),
                         (k <= 32) ? k : 0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_periodic();
        do_reset();
        terminal = 6'd5; auto_reload = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; auto_reload = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            abort = (k == 22);
            #1;
            n_chk++;
            if (o_ready[0] !== ((k % 5) == 0 && k != 22) || o_count[0] !== 6'(((k - 1) % 5) + 1)) begin
                n_err++;
                $display("FAIL periodic cycle %0d: ready=%b count=%0d, want %b %0d",
                         k, o_ready[0], o_count[0], (k % 5) == 0, ((k - 1) % 5) + 1);
            end
            @(posedge clk); #1;
        end
        abort = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            n_chk++;
            if (o_ready[0] !== 1'b0 || o_busy[0] !== 1'b0 || o_count[0] !== 6'd0) begin
                n_err++;
                $display("FAIL periodic_abort +%0d: ready=%b busy=%b count=%0d, want 0 0 0",
                         k, o_ready[0], o_busy[0], o_count[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sticky();
        do_reset();
        terminal = 6'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            ack = (k == 10);
            #1;
            n_chk++;
            if (o_ready[1] !== (k >= 3 && k <= 10) || o_busy[1] !== (k <= 3) ||
                o_count[1] !== ((k <= 3) ? 6'(k) : ((k <= 10) ? 6'd3 : 6'd0))) begin
                n_err++;
                $display("FAIL sticky cycle %0d: ready=%b busy=%b count=%0d, want %b %b %0d",
                         k, o_ready[1], o_busy[1], o_count[1], (k >= 3 && k <= 10), (k <= 3),
                         (k <= 3) ? k : ((k <= 10) ? 3 : 0));
            end
            @(posedge clk); #1;
        end
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        terminal = 6'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            #1;
            n_chk++;
            if (o_ready[0] !== (k == 1) || o_busy[0] !== (k == 1) || o_count[0] !== ((k == 1) ? 6'd1 : 6'd0)) begin
                n_err++;
                $display("FAIL term0 cycle %0d: ready=%b busy=%b count=%0d, want %b %b %0d",
                         k, o_ready[0], o_busy[0], o_count[0], (k == 1), (k == 1), (k == 1) ? 1 : 0);
            end
            @(posedge clk); #1;
        end
        do_reset();
        terminal = 6'd4; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 16; k++) begin
            #1;
            n_chk++;
            if (o_ready[0] !== ((k % 4) == 0) || o_count[0] !== 6'(((k - 1) % 4) + 1) || o_ovr[0] !== (k >= 2)) begin
                n_err++;
                $display("FAIL held_start cycle %0d: ready=%b count=%0d ovr=%b, want %b %0d %b",
                         k, o_ready[0], o_count[0], o_ovr[0], (k % 4) == 0, ((k - 1) % 4) + 1, (k >= 2));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        terminal = 6'd32; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 17; k++) begin
            start = (k == 5);
            reset = (k == 17);
            if (k == 17) begin
                #1;
                n_chk++;
                if (o_count[0] !== 6'd17 || o_ovr[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL pre_reset: count=%0d ovr=%b, want 17 1", o_count[0], o_ovr[0]);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; start = 1'b0;
        #1;
        n_chk++;
        if (o_count[0] !== 6'd0 || o_busy[0] !== 1'b0 || o_ovr[0] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: count=%0d busy=%b ovr=%b, want 0 0 0", o_count[0], o_busy[0], o_ovr[0]);
        end
        for (int k = 0; k < 40; k++) begin
            n_chk++;
            if (o_ready[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL post_reset +%0d: ready=%b busy=%b, want 0 0", k, o_ready[0], o_busy[0]);
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_random();
        bit       e_busy, e_ready, e_ovr;
        bit       fin;
        int       e_cnt;
        do_reset();
        for (int s = 0; s < 2; s++) begin
            m_run[s] = 1'b0; m_done[s] = 1'b0; m_per[s] = 1'b0; m_ovr[s] = 1'b0;
            m_n[s] = 0; m_T[s] = 1;
        end
        for (int c = 0; c < 600; c++) begin
            start       = ($urandom_range(0, 3) == 0);
            abort       = ($urandom_range(0, 24) == 0);
            ack         = ($urandom_range(0, 3) == 0);
            auto_reload = ($urandom_range(0, 2) == 0);
            reset       = ($urandom_range(0, 99) == 0);
            terminal    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
            #1;
            for (int s = 0; s < 2; s++) begin
                fin     = m_run[s] && (m_n[s] == m_T[s]);
                e_busy  = m_run[s];
                e_ready = !abort && (fin || m_done[s]);
                e_cnt   = m_run[s] ? m_n[s] : (m_done[s] ? m_T[s] : 0);
                e_ovr   = m_ovr[s];
                n_chk++;
                if (o_busy[s] !== e_busy || o_ready[s] !== e_ready ||
                    o_count[s] !== 6'(e_cnt) || o_ovr[s] !== e_ovr) begin
                    n_err++;
                    $display("FAIL random c%0d inst%0d: busy=%b ready=%b count=%0d ovr=%b, want %b %b %0d %b",
                             c, s, o_busy[s], o_ready[s], o_count[s], o_ovr[s], e_busy, e_ready, e_cnt, e_ovr);
                end
            end
            @(posedge clk);
            for (int s = 0; s < 2; s++) begin
                fin = m_run[s] && (m_n[s] == m_T[s]);
                if (reset) begin
                    m_run[s] = 1'b0; m_done[s] = 1'b0; m_per[s] = 1'b0; m_ovr[s] = 1'b0;
                    m_n[s] = 0; m_T[s] = 1;
                end else if (abort) begin
                    m_run[s] = 1'b0; m_done[s] = 1'b0;
                end else if (fin && m_per[s]) begin
                    m_n[s] = 1;
                end else if ((fin || !m_run[s]) && start) begin
                    m_run[s] = 1'b1; m_done[s] = 1'b0; m_n[s] = 1;
                    m_T[s] = (terminal == 6'd0) ? 1 : int'(terminal);
                    m_per[s] = auto_reload;
                end else if (fin) begin
                    m_run[s]  = 1'b0;
                    m_done[s] = (s == 1) && !ack;
                end else if (m_run[s]) begin
                    m_n[s] = m_n[s] + 1;
                    if (start) m_ovr[s] = 1'b1;
                end else if (m_done[s] && ack) begin
                    m_done[s] = 1'b0;
                end
            end
            #1;
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
        auto_reload = 1'b0; terminal = 6'd0;
        @(posedge clk); #1;
        test_reset();
        test_one_shot();
        test_periodic();
        test_sticky();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/op_cycle_counter.md
OP_CYCLE_COUNTER -- requirements
Module: op_cycle_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 6: width of count and terminal (max terminal 2^WIDTH-1).
REQ-002 SHALL have parameter STICKY, default 0: 0 = ready is a one-cycle pulse; 1 = ready held until ack.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: request to begin a count; sampled each rising edge.
REQ-006 SHALL have port terminal, input, WIDTH: cycle count to wait; sampled only when start is accepted.
REQ-007 SHALL have port auto_reload, input, 1: periodic mode; sampled only when start is accepted.
REQ-008 SHALL have port abort, input, 1: cancel any count in progress.
REQ-009 SHALL have port ack, input, 1: clears held ready (used only when STICKY=1).
REQ-010 SHALL have port busy, output, 1: high in RUN.
REQ-011 SHALL have port ready, output, 1: completion indication.
REQ-012 SHALL have port count, output, WIDTH: current count value.
REQ-013 SHALL have port overrun, output, 1: sticky flag, start seen while busy.

Function
REQ-014 SHALL implement states IDLE, RUN and DONE; DONE is reachable only when STICKY=1.
REQ-015 SHALL accept start in IDLE or DONE: latch term_q = max(terminal,1) and reload_q = auto_reload, set count=1, go RUN.
REQ-016 SHALL increment count by 1 per cycle in RUN while count != term_q; count never exceeds term_q and never wraps.
REQ-017 SHALL drive ready high combinationally when state=RUN and count==term_q (terminal cycle), i.e. exactly T cycles after the start edge, where T = max(terminal,1).
REQ-018 At the terminal cycle, if reload_q=1, SHALL set count=1 and stay in RUN (periodic pulse every T cycles), regardless of STICKY.
REQ-019 At the terminal cycle, if reload_q=0 and STICKY=0, SHALL go to IDLE with count=0.
REQ-020 At the terminal cycle, if reload_q=0 and STICKY=1, SHALL go to DONE, unless ack is high in that cycle, in which case it SHALL go to IDLE.
REQ-021 In DONE, SHALL hold ready=1, busy=0 and count=term_q; ack SHALL move it to IDLE with count=0, and start SHALL take precedence per REQ-015 (implicit ack).
REQ-022 start in the terminal cycle with reload_q=0 SHALL be accepted (back-to-back operation): ready pulses, then the next edge enters RUN with count=1.
REQ-023 start while in RUN outside the terminal cycle SHALL be ignored and SHALL set overrun=1; overrun clears only on reset.
REQ-024 abort SHALL force IDLE, count=0 and ready=0 (combinational ready masked by abort) with priority over start, ack and terminal handling, without touching overrun.
REQ-025 In IDLE, outputs SHALL be busy=0, ready=0, count=0.

Reset
REQ-026 reset SHALL be synchronous and active-high and SHALL take priority over all inputs.
REQ-027 On reset, SHALL set state=IDLE, count=0, term_q=1, reload_q=0 and overrun=0, giving busy=0 and ready=0.
REQ-028 reset asserted mid-count SHALL abandon the count with no ready pulse.

Structure
REQ-029 The state encoding (IDLE=0, RUN=1, DONE=2, 2-bit) SHALL live in a shared package, op_counter_pkg, for reuse by the multdiv control.
REQ-030 One sub-module, regn (WIDTH-parametrised register with synchronous reset and enable), SHALL hold count, term_q and the state register.
REQ-031 The incrementer and the equality compare SHALL be inline logic; no ALU instance is required.

Verification
REQ-032 One-shot: WIDTH=6, STICKY=0, start with terminal=32 -> ready high for exactly 1 cycle, 32 cycles after the start edge; busy high 32 cycles; count returns to 0.
REQ-033 Periodic: terminal=5, auto_reload=1 -> ready every 5 cycles for 4 periods; abort -> idle, no further pulses.
REQ-034 Sticky: STICKY=1, terminal=3 -> ready rises at cycle 3, held until ack at cycle 10, then ready=0 and count=0 on the next cycle.
REQ-035 Boundaries: terminal=0 -> ready 1 cycle after start; start held high continuously with terminal=4 -> ready every 4 cycles and overrun=1.
REQ-036 Reset: reset at count=17 of terminal=32 -> next cycle count=0, busy=0, overrun=0, and no ready for 40 subsequent cycles.
